// File: rtl/pipe_stage_hs_if.sv
// pipe_stage_hs_if
//  Valid/ready/data bundle for one side of a pipeline stage boundary.
//  Parameter:
//   WIDTH  payload width in bits
//  Signals:
//   valid  producer has a beat this cycle
//   ready  consumer accepts a beat this cycle
//   data   payload of the offered beat
//  Modports:
//   master  producer side (drives valid/data, observes ready)
//   slave   consumer side (observes valid/data, drives ready)
interface pipe_stage_hs_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs
//  Generic pipeline stage register with valid/ready handshake, flush and a
//  saturating back-pressure counter. One instance sits on each stage boundary
//  and carries a packed WIDTH-bit stage bundle with one cycle of latency.
//  Optional feature (compile-time macro PIPE_SKID_EN):
//   defined   - 1-entry skid register, registered in_ready = !skid_valid,
//               capacity 2 beats, strict FIFO order (main before skid)
//   undefined - in_ready = !out_valid | out_ready (combinational), capacity 1
//  Parameters:
//   WIDTH  payload width in bits
//   CNT_W  width of stall_cnt
//  Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   in_if      upstream side (slave): valid/data in, ready out
//   out_if     downstream side (master): valid/data out, ready in
//   flush      discard all held beats, including one accepted this cycle
//   cnt_clr    clear stall_cnt (wins over an increment)
//   stall_cnt  cycles with out_valid & !out_ready, saturating at all-ones
module pipe_stage_hs #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_stage_hs_if.slave         in_if,
  pipe_stage_hs_if.master        out_if,
  input  logic                   flush,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_in_ready;
  logic w_in_acc;
  logic w_out_acc;
  logic w_stalled;

  assign w_out_acc = r_out_valid & out_if.ready;
  assign w_stalled = r_out_valid & ~out_if.ready;
  assign w_in_acc  = in_if.valid & w_in_ready;

`ifdef PIPE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  // Registered ready: upstream timing never sees out_ready.
  assign w_in_ready = ~r_skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (flush) begin
      // Drop both held beats and anything offered this cycle; main data
      // is left as-is since out_valid already marks it dead.
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_acc && r_skid_valid) begin
      // Head leaves, skid beat moves up. in_ready is low, so no new beat.
      r_out_data   <= r_skid_data;
      r_out_valid  <= 1'b1;
      r_skid_valid <= 1'b0;
    end else if (w_in_acc && !w_stalled) begin
      r_out_data  <= in_if.data;
      r_out_valid <= 1'b1;
    end else if (w_in_acc) begin
      // Head is stuck: park the new beat behind it.
      r_skid_data  <= in_if.data;
      r_skid_valid <= 1'b1;
    end else if (w_out_acc) begin
      r_out_valid <= 1'b0;
    end
  end
`else
  // Single-entry stage: a beat may enter whenever the head is empty or leaving.
  assign w_in_ready = ~r_out_valid | out_if.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_acc && !w_stalled) begin
      r_out_data  <= in_if.data;
      r_out_valid <= 1'b1;
    end else if (w_out_acc) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  // Back-pressure counter; independent of flush.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stalled && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_if.ready  = w_in_ready;
  assign out_if.valid = r_out_valid;
  assign out_if.data  = r_out_data;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs
//  Scoreboard bench for pipe_stage_hs. The reference model is a queue of
//  beats held by the stage: accepted beats are appended, delivered beats are
//  popped, flush/reset empties it. Stage capacity is 1 beat, or 2 when
//  PIPE_SKID_EN is defined. A second instance with CNT_W=4 exercises
//  stall counter saturation.
module tb_pipe_stage_hs;

  localparam int W = 16;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [7:0]   stall_cnt;
  logic         cnt_clr4 = 1'b0;
  logic         flush4 = 1'b0;
  logic [3:0]   stall_cnt4;

  pipe_stage_hs_if #(.WIDTH(W)) in_if ();
  pipe_stage_hs_if #(.WIDTH(W)) out_if ();
  pipe_stage_hs_if #(.WIDTH(W)) in4_if ();
  pipe_stage_hs_if #(.WIDTH(W)) out4_if ();

  pipe_stage_hs #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (in_if),
    .out_if    (out_if),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_hs #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_if     (in4_if),
    .out_if    (out4_if),
    .flush     (flush4),
    .cnt_clr   (cnt_clr4),
    .stall_cnt (stall_cnt4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int delivered = 0;
  int dropped = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_cnt = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                      input logic fl, input logic clr);
    logic acc;
    in_if.valid  = v;
    in_if.data   = d;
    out_if.ready = ordy;
    flush        = fl;
    cnt_clr      = clr;
    @(negedge clk);
    acc = v && in_if.ready && !fl && !rst;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(d);
      accepted++;
    end
    #1;
  endtask

  // Monitor: data/counter checks and model update, mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("stall_cnt", {24'd0, stall_cnt}, {24'd0, exp_cnt});
      if (exp_q.size() > 0)
        chk("out_data", {16'd0, out_if.data}, {16'd0, exp_q[0]});
      if (rst || cnt_clr)
        exp_cnt = 8'd0;
      else if (exp_q.size() > 0 && !out_if.ready && exp_cnt != 8'hFF)
        exp_cnt = exp_cnt + 8'd1;
      if (exp_q.size() > 0 && out_if.ready) begin
        $display("beat %0d data %h", delivered, exp_q[0]);
        void'(exp_q.pop_front());
        delivered++;
      end
      if (flush || rst) begin
        dropped += exp_q.size();
        exp_q.delete();
      end
    end
  end

  // Monitor: occupancy-derived valid/ready checks just after each edge.
  always @(posedge clk) begin
    if (mon_en) begin
      #2;
      chk("out_valid", {31'd0, out_if.valid}, {31'd0, exp_q.size() > 0});
      chk("in_ready", {31'd0, in_if.ready},
          {31'd0, (exp_q.size() < CAP) || (CAP == 1 && out_if.ready)});
    end
  end

  initial begin
    in_if.valid   = 1'b1;
    in_if.data    = 16'h1234;
    out_if.ready  = 1'b1;
    in4_if.valid  = 1'b0;
    in4_if.data   = '0;
    out4_if.ready = 1'b1;

    // Reset held two cycles with a beat offered.
    @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_out_data", {16'd0, out_if.data}, 32'd0);
    chk("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_if.ready}, 32'd1);
    chk("rst_stall_cnt", {24'd0, stall_cnt}, 32'd0);

    // Streaming at full rate, one-cycle latency.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_valid", {31'd0, out_if.valid}, 32'd1);
      chk("stream_data", {16'd0, out_if.data}, i);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: hold 0xAA for 5 cycles, offer 0xBB during the stall.
    step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("stall5_cnt", {24'd0, stall_cnt}, 32'd5);
    chk("stall5_data", {16'd0, out_if.data}, 32'h00AA);
    chk("stall5_in_ready", {31'd0, in_if.ready}, 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with stage full and a new beat offered.
    step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00CC, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", {31'd0, out_if.valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_if.ready}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Counter saturation on the CNT_W=4 instance.
    in4_if.valid  = 1'b1;
    in4_if.data   = 16'h0055;
    out4_if.ready = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    in4_if.valid = 1'b0;
    for (int i = 0; i < 14; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt14", {28'd0, stall_cnt4}, 32'd14);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("sat_cnt15", {28'd0, stall_cnt4}, 32'd15);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("sat_hold", {28'd0, stall_cnt4}, 32'd15);
    chk("sat_data", {16'd0, out4_if.data}, 32'h0055);
    cnt_clr4 = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cnt_clr4 = 1'b0;
    chk("sat_clr", {28'd0, stall_cnt4}, 32'd0);
    out4_if.ready = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("sat_drain", {31'd0, out4_if.valid}, 32'd0);

    // Random traffic until 1000 further beats are accepted.
    begin
      int target = accepted + 1000;
      int guard = 0;
      while (accepted < target && guard < 20000) begin
        step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 4) < 3,
             $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
        guard++;
      end
      chk("random_beats_reached", {31'd0, accepted >= target}, 32'd1);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("beat_count", delivered + dropped, accepted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
